// File: rtl/spi_flash_reader.sv
// SPI-NOR READ (0x03) sequencer: drives spi_master's transfer interface and
// returns the read bytes one at a time on a valid/ready stream.
`timescale 1ns/1ps

module spi_flash_reader #(
   parameter logic [7:0] READ_CMD   = 8'h03,
   parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        rd_req,
   input  logic [23:0] rd_addr,
   input  logic [15:0] rd_len,
   output logic        busy,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        rd_done,
   output logic        spi_en,
   output logic [1:0]  spi_mode,
   output logic [15:0] spi_sdata,
   input  logic [15:0] spi_rdata,
   input  logic        spi_done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_OUT  = 3'd4;
   localparam logic [2:0] S_FIN  = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [15:0] cnt_q, cnt_d;
   logic        entry_q, entry_d;
   logic        busy_q, busy_d;
   logic [7:0]  rd_data_q, rd_data_d;
   logic        rd_valid_q, rd_valid_d;
   logic        rd_done_q, rd_done_d;
   logic        spi_en_q, spi_en_d;
   logic [1:0]  spi_mode_q, spi_mode_d;
   logic [15:0] spi_sdata_q, spi_sdata_d;

   // Only the low byte of an 8-bit transfer carries read data.
   logic unused_rdata_hi;
   assign unused_rdata_hi = ^spi_rdata[15:8];

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case
      // leaves one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      entry_d     = 1'b0;
      busy_d      = busy_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = rd_valid_q;
      rd_done_d   = 1'b0;
      spi_en_d    = 1'b0;
      spi_mode_d  = spi_mode_q;
      spi_sdata_d = spi_sdata_q;

      // entry_q marks the first cycle of a transfer state: that cycle launches
      // the transfer, and spi_done is only honoured once it is in flight.
      case (state_q)
         S_IDLE: begin
            if (rd_req) begin
               addr_d = rd_addr;
               cnt_d  = rd_len;
               busy_d = 1'b1;
               if (rd_len == 16'd0) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_CMD;
                  entry_d = 1'b1;
               end
            end
         end
         S_CMD: begin
            if (entry_q) begin
               spi_en_d    = 1'b1;
               spi_mode_d  = 2'b11;
               spi_sdata_d = {READ_CMD, addr_q[23:16]};
            end else if (spi_done) begin
               state_d = S_ADDR;
               entry_d = 1'b1;
            end
         end
         S_ADDR: begin
            if (entry_q) begin
               spi_en_d    = 1'b1;
               spi_mode_d  = 2'b11;
               spi_sdata_d = addr_q[15:0];
            end else if (spi_done) begin
               state_d = S_DATA;
               entry_d = 1'b1;
            end
         end
         S_DATA: begin
            if (entry_q) begin
               spi_en_d    = 1'b1;
               // The last byte releases CS; earlier ones keep the burst open.
               spi_mode_d  = (cnt_q == 16'd1) ? 2'b00 : 2'b01;
               spi_sdata_d = {DUMMY_BYTE, 8'h00};
            end else if (spi_done) begin
               rd_data_d  = spi_rdata[7:0];
               cnt_d      = cnt_q - 16'd1;
               rd_valid_d = 1'b1;
               state_d    = S_OUT;
            end
         end
         S_OUT: begin
            if (rd_ready) begin
               rd_valid_d = 1'b0;
               if (cnt_q != 16'd0) begin
                  state_d = S_DATA;
                  entry_d = 1'b1;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_FIN: begin
            rd_done_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of order.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         entry_q     <= 1'b0;
         busy_q      <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         rd_done_q   <= 1'b0;
         spi_en_q    <= 1'b0;
         spi_mode_q  <= '0;
         spi_sdata_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         entry_q     <= entry_d;
         busy_q      <= busy_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         rd_done_q   <= rd_done_d;
         spi_en_q    <= spi_en_d;
         spi_mode_q  <= spi_mode_d;
         spi_sdata_q <= spi_sdata_d;
      end
   end

   assign busy      = busy_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign rd_done   = rd_done_q;
   assign spi_en    = spi_en_q;
   assign spi_mode  = spi_mode_q;
   assign spi_sdata = spi_sdata_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a behavioural spi_master answers each transfer,
// and scoreboard queues hold the expected transfers and read bytes.
`timescale 1ns/1ps

module tb_spi_flash_reader;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        rd_req    = 1'b0;
   logic [23:0] rd_addr   = '0;
   logic [15:0] rd_len    = '0;
   logic        busy;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic        rd_ready  = 1'b1;
   logic        rd_done;
   logic        spi_en;
   logic [1:0]  spi_mode;
   logic [15:0] spi_sdata;
   logic [15:0] spi_rdata = '0;
   logic        spi_done  = 1'b0;

   spi_flash_reader dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_len    (rd_len),
      .busy      (busy),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_done   (rd_done),
      .spi_en    (spi_en),
      .spi_mode  (spi_mode),
      .spi_sdata (spi_sdata),
      .spi_rdata (spi_rdata),
      .spi_done  (spi_done)
   );

   always #10 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int n_en = 0, n_done = 0, n_beats = 0, n_busy = 0;
   int last_hs = 0, last_done = 0, last_sdone = 0, req_cyc = 0, first_en = -1;
   logic hs_pend = 1'b0;

   logic [17:0] exp_xfer_q [$];
   logic [7:0]  src_byte_q [$];
   logic [7:0]  exp_byte_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge sys_clk);
      cyc++;
   end

   // Behavioural spi_master: spi_done three cycles after spi_en.
   initial begin : spi_model
      int          cdown = 0;
      logic        nxt = 1'b0;
      logic [7:0]  nxt_byte = '0;
      logic [1:0]  cap_mode = '0;
      logic [15:0] cap_sdata = '0;
      logic [17:0] e;
      forever begin
         @(negedge sys_clk);
         nxt = 1'b0;
         nxt_byte = '0;
         if (!sys_rst_n) begin
            cdown = 0;
         end else begin
            if (spi_done) begin
               check("mode_hold", 32'(spi_mode), 32'(cap_mode));
               check("sdata_hold", 32'(spi_sdata), 32'(cap_sdata));
               if (!cap_mode[1]) last_sdone = cyc;
            end
            if (spi_en) begin
               n_en++;
               if (first_en < 0) first_en = cyc;
               if (hs_pend) begin
                  check("en_after_hs", 32'(cyc - last_hs), 32'd2);
                  hs_pend = 1'b0;
               end
               cap_mode  = spi_mode;
               cap_sdata = spi_sdata;
               cdown     = 3;
               e = (exp_xfer_q.size() != 0) ? exp_xfer_q.pop_front() : 'x;
               check("xfer", 32'({spi_mode, spi_sdata}), 32'(e));
            end else if (cdown > 0) begin
               cdown--;
               if (cdown == 0) begin
                  nxt = 1'b1;
                  if (!cap_mode[1])
                     nxt_byte = (src_byte_q.size() != 0) ? src_byte_q.pop_front() : 8'h00;
               end
            end
         end
         @(posedge sys_clk);
         #1;
         spi_done  = nxt;
         spi_rdata = nxt ? {8'hE7, nxt_byte} : 16'h0000;
      end
   end

   // Consumer-side monitor: data order, hold-while-valid, done timing.
   initial begin : rd_monitor
      logic       pv = 1'b0;
      logic       phs = 1'b0;
      logic [7:0] pd = '0;
      logic [7:0] e;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            pv  = 1'b0;
            phs = 1'b0;
         end else begin
            if (busy) n_busy++;
            if (rd_valid && !pv) check("valid_rise", 32'(cyc - last_sdone), 32'd1);
            if (pv && !phs) begin
               check("valid_held", 32'(rd_valid), 32'd1);
               check("data_held", 32'(rd_data), 32'(pd));
            end
            phs = rd_valid && rd_ready;
            if (phs) begin
               n_beats++;
               last_hs = cyc;
               hs_pend = 1'b1;
               e = (exp_byte_q.size() != 0) ? exp_byte_q.pop_front() : 'x;
               check("rd_data", 32'(rd_data), 32'(e));
            end
            if (rd_done) begin
               n_done++;
               last_done = cyc;
               hs_pend   = 1'b0;
               check("busy_at_done", 32'(busy), 32'd0);
            end
            pv = rd_valid;
            pd = rd_data;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic start(input logic [23:0] a, input logic [15:0] len,
                        input logic [7:0] b0, input logic [7:0] step);
      if (len != 16'd0) begin
         exp_xfer_q.push_back({2'b11, 8'h03, a[23:16]});
         exp_xfer_q.push_back({2'b11, a[15:0]});
         for (int i = 0; i < int'(len); i++) begin
            exp_xfer_q.push_back({(i == int'(len) - 1) ? 2'b00 : 2'b01, 16'h0000});
            src_byte_q.push_back(8'(b0 + 8'(i) * step));
            exp_byte_q.push_back(8'(b0 + 8'(i) * step));
         end
      end
      first_en = -1;
      rd_addr  = a;
      rd_len   = len;
      rd_req   = 1'b1;
      req_cyc  = cyc;
      tick();
      rd_req   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0 = n_done;
      int k = 0;
      while (n_done == d0 && k < budget) begin
         tick();
         k++;
      end
      check("done_seen", 32'(n_done != d0), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (!rd_valid && k < budget) begin
         tick();
         k++;
      end
      check("valid_seen", 32'(rd_valid), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_done"},  32'(rd_done), 32'd0);
      check({tag, "_en"},    32'(spi_en), 32'd0);
      check({tag, "_mode"},  32'(spi_mode), 32'd0);
      check({tag, "_sdata"}, 32'(spi_sdata), 32'd0);
      check({tag, "_data"},  32'(rd_data), 32'd0);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_xfer_left"}, 32'(exp_xfer_q.size()), 32'd0);
      check({tag, "_byte_left"}, 32'(exp_byte_q.size()), 32'd0);
   endtask

   initial begin
      int e0, b0, d0, nb, es;

      // Reset state
      tick(3);
      check_reset_outputs("reset");
      sys_rst_n = 1'b1;
      tick(2);

      // Single byte read
      e0 = n_en; b0 = n_beats;
      start(24'h012345, 16'd1, 8'hA5, 8'h00);
      wait_done(200);
      check("t1_en_count", 32'(n_en - e0), 32'd3);
      check("t1_beats", 32'(n_beats - b0), 32'd1);
      check("t1_en_lat", 32'(first_en - req_cyc), 32'd2);
      check("t1_done_lat", 32'(last_done - last_hs), 32'd2);
      check("t1_busy_after", 32'(busy), 32'd0);
      check_drained("t1");
      tick(3);

      // Four-byte burst, consumer always ready
      e0 = n_en; b0 = n_beats;
      start(24'hA0B0C0, 16'd4, 8'h11, 8'h11);
      wait_done(300);
      check("t2_en_count", 32'(n_en - e0), 32'd6);
      check("t2_beats", 32'(n_beats - b0), 32'd4);
      check("t2_done_lat", 32'(last_done - last_hs), 32'd2);
      check_drained("t2");
      tick(3);

      // Consumer stall on the second beat
      rd_ready = 1'b0;
      e0 = n_en; b0 = n_beats;
      start(24'h00FF00, 16'd3, 8'h5A, 8'h10);
      for (int beat = 0; beat < 3; beat++) begin
         wait_valid(100);
         if (beat == 1) begin
            es = n_en;
            tick(20);
            check("t3_no_en_stall", 32'(n_en), 32'(es));
            check("t3_valid_stall", 32'(rd_valid), 32'd1);
         end
         rd_ready = 1'b1;
         tick();
         rd_ready = 1'b0;
      end
      wait_done(100);
      rd_ready = 1'b1;
      check("t3_en_count", 32'(n_en - e0), 32'd5);
      check("t3_beats", 32'(n_beats - b0), 32'd3);
      check_drained("t3");
      tick(3);

      // Zero-length read
      e0 = n_en; nb = n_busy;
      start(24'hABCDEF, 16'd0, 8'h00, 8'h00);
      wait_done(20);
      tick(5);
      check("t4_en_count", 32'(n_en - e0), 32'd0);
      check("t4_busy_cycles", 32'(n_busy - nb), 32'd1);
      check("t4_done_lat", 32'(last_done - req_cyc), 32'd2);

      // Second request while busy is ignored
      e0 = n_en; b0 = n_beats; d0 = n_done;
      start(24'h400000, 16'd2, 8'hC0, 8'h01);
      tick(6);
      rd_addr = 24'hFFFFFF;
      rd_len  = 16'd7;
      rd_req  = 1'b1;
      tick();
      rd_req  = 1'b0;
      wait_done(300);
      tick(30);
      check("t5_en_count", 32'(n_en - e0), 32'd4);
      check("t5_done_count", 32'(n_done - d0), 32'd1);
      check("t5_beats", 32'(n_beats - b0), 32'd2);
      check_drained("t5");

      // Reset during the address transfer
      e0 = n_en;
      start(24'h777777, 16'd2, 8'h99, 8'h01);
      begin
         int k = 0;
         while (n_en < e0 + 2 && k < 100) begin
            tick();
            k++;
         end
         check("t6_addr_seen", 32'(n_en - e0), 32'd2);
      end
      tick();
      #3;
      sys_rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_xfer_q.delete();
      src_byte_q.delete();
      exp_byte_q.delete();
      hs_pend = 1'b0;
      tick(3);
      sys_rst_n = 1'b1;
      tick(2);
      e0 = n_en; b0 = n_beats; d0 = n_done;
      start(24'h000010, 16'd2, 8'h3C, 8'h01);
      wait_done(300);
      check("t6_en_count", 32'(n_en - e0), 32'd4);
      check("t6_beats", 32'(n_beats - b0), 32'd2);
      check("t6_done_count", 32'(n_done - d0), 32'd1);
      check_drained("t6");
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
